wasm_prog_loader: RTL and testbench
===================================

WASM_PROG_LOADER -- requirements
Module: wasm_prog_loader

Interface
REQ-001 Parameter: ADDR_W, default `instr_log2_bram_depth, instruction BRAM address width; depth = 2^ADDR_W bytes.
REQ-002 Parameter: TIMEOUT, default 500, maximum RUN cycles before abort.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  one-cycle pulse; begins a load, accepted only in IDLE or DONE.
REQ-006 i_byte_valid  in  1  program byte present.
REQ-007 i_byte  in  8  program byte (hex-image byte order, address 0 first).
REQ-008 i_byte_last  in  1  qualifies the final program byte; sampled with i_byte_valid.
REQ-009 o_byte_ready  out  1  loader accepts a byte this cycle.
REQ-010 o_bram_we  out  1  instruction BRAM write enable.
REQ-011 o_bram_addr  out  ADDR_W  BRAM write address.
REQ-012 o_bram_wdata  out  8  BRAM write data.
REQ-013 o_cpu_rst_n  out  1  active-low reset driven to WASM_TOP i_rst_n.
REQ-014 i_instr_finish, i_instr_error, i_stack_exceed, i_stack_empty_pop  in  1 each  WASM_TOP status outputs.
REQ-015 o_done  out  1  run complete; status and count valid.
REQ-016 o_status  out  3  0 OK, 1 INSTR_ERROR, 2 STACK_EXCEED, 3 EMPTY_POP, 4 TIMEOUT, 5 OVERFLOW.
REQ-017 o_cycle_cnt  out  32  CPU cycles counted in RUN.
REQ-018 o_prog_len  out  ADDR_W+1  bytes written in last load.

Function
REQ-019 FSM states IDLE, LOAD, FLUSH, RUN, DONE; registered state, all outputs registered.
REQ-020 IDLE/DONE: i_start -> LOAD at next edge; clears o_prog_len, o_cycle_cnt, o_status, o_done.
REQ-021 LOAD: o_byte_ready=1; transfer = i_byte_valid & o_byte_ready; each transfer registers o_bram_we=1, o_bram_addr=o_prog_len, o_bram_wdata=i_byte for exactly the following cycle, and increments o_prog_len.
REQ-022 LOAD: no transfer -> o_bram_we=0 next cycle, no state change; valid without ready is never written.
REQ-023 Transfer with i_byte_last=1 -> FLUSH; o_byte_ready=0 from the next cycle.
REQ-024 Transfer at address 2^ADDR_W-1 with i_byte_last=0 -> byte written, o_status=5, state DONE, CPU never released.
REQ-025 FLUSH: lasts one cycle, final write completes, then RUN; o_cpu_rst_n=0 in IDLE, LOAD, FLUSH, DONE.
REQ-026 RUN: o_cpu_rst_n=1; o_cycle_cnt increments by 1 each RUN cycle with no terminating event, starting from 0.
REQ-027 RUN terminating events, priority high->low: i_instr_error (1), i_stack_exceed (2), i_stack_empty_pop (3), i_instr_finish (0), o_cycle_cnt==TIMEOUT-1 (4).
REQ-028 On a terminating event: o_status set, o_cycle_cnt frozen (not incremented that cycle), state DONE, o_done=1, o_cpu_rst_n=0 from next cycle.
REQ-029 Status inputs ignored outside RUN.
REQ-030 DONE: outputs hold until i_start; i_start in LOAD/FLUSH/RUN ignored.
REQ-031 o_cycle_cnt saturates at 2^32-1 (unreachable under TIMEOUT but required).

Reset
REQ-032 i_rst_n low at any time, including mid-LOAD or mid-RUN -> immediately: state IDLE, o_byte_ready=0, o_bram_we=0, o_bram_addr=0, o_bram_wdata=0, o_cpu_rst_n=0, o_done=0, o_status=0, o_cycle_cnt=0, o_prog_len=0.
REQ-033 Partially loaded BRAM content after reset is undefined; a new i_start reloads from address 0.

Verification
REQ-034 Load 4 bytes 41 01 41 02 (last on 4th), CPU pulses finish 10 RUN cycles later -> BRAM 0..3 = 41,01,41,02; o_prog_len=4; o_status=0; o_cycle_cnt=10; o_done=1.
REQ-035 Bytes with valid toggling every other cycle -> exactly one write per transfer, addresses 0,1,2 contiguous, no duplicate writes.
REQ-036 i_instr_error and i_instr_finish same RUN cycle -> o_status=1.
REQ-037 CPU never finishes, TIMEOUT=500 -> o_status=4, o_cycle_cnt=499, o_cpu_rst_n=0 next cycle.
REQ-038 ADDR_W=4, 16 bytes, none last -> 16 writes, o_status=5, o_prog_len=16, o_cpu_rst_n stays 0.
REQ-039 i_rst_n asserted during RUN at cycle 5 -> all outputs at reset values same cycle; then i_start + 2-byte load runs normally with o_cycle_cnt restarting at 0.

Source files
------------

// File: rtl/wasm_prog_loader.sv
// Streams a program image into instruction BRAM, then releases the WASM core
// and records how its run ended (status, cycle count, program length).
`ifndef INSTR_LOG2_BRAM_DEPTH
`define INSTR_LOG2_BRAM_DEPTH 10
`endif

module wasm_prog_loader #(
  parameter int ADDR_W  = `INSTR_LOG2_BRAM_DEPTH,
  parameter int TIMEOUT = 500
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_last,
  output logic              o_byte_ready,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [7:0]        o_bram_wdata,
  output logic              o_cpu_rst_n,
  input  logic              i_instr_finish,
  input  logic              i_instr_error,
  input  logic              i_stack_exceed,
  input  logic              i_stack_empty_pop,
  output logic              o_done,
  output logic [2:0]        o_status,
  output logic [31:0]       o_cycle_cnt,
  output logic [ADDR_W:0]   o_prog_len
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE} state_e;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_INSTR_ERR = 3'd1;
  localparam logic [2:0] ST_STACK_EXC = 3'd2;
  localparam logic [2:0] ST_EMPTY_POP = 3'd3;
  localparam logic [2:0] ST_TIMEOUT   = 3'd4;
  localparam logic [2:0] ST_OVERFLOW  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR    = '1;
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0]       CNT_MAX      = '1;

  state_e              state_q, state_d;
  logic                byteReady_q, byteReady_d;
  logic                bramWe_q, bramWe_d;
  logic [ADDR_W-1:0]   bramAddr_q, bramAddr_d;
  logic [7:0]          bramWdata_q, bramWdata_d;
  logic                cpuRstN_q, cpuRstN_d;
  logic                done_q, done_d;
  logic [2:0]          status_q, status_d;
  logic [31:0]         cycleCnt_q, cycleCnt_d;
  logic [ADDR_W:0]     progLen_q, progLen_d;

  logic                transfer;
  logic                runEnd;
  logic [2:0]          runCode;

  assign transfer = i_byte_valid & byteReady_q;

  // Run termination, highest priority first; timeout only when the core is silent.
  always_comb begin
    runEnd  = 1'b1;
    runCode = ST_OK;
    if (i_instr_error)                  runCode = ST_INSTR_ERR;
    else if (i_stack_exceed)            runCode = ST_STACK_EXC;
    else if (i_stack_empty_pop)         runCode = ST_EMPTY_POP;
    else if (i_instr_finish)            runCode = ST_OK;
    else if (cycleCnt_q == TIMEOUT_LAST) runCode = ST_TIMEOUT;
    else                                runEnd = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    byteReady_d = byteReady_q;
    bramWe_d    = 1'b0;
    bramAddr_d  = bramAddr_q;
    bramWdata_d = bramWdata_q;
    cpuRstN_d   = cpuRstN_q;
    done_d      = done_q;
    status_d    = status_q;
    cycleCnt_d  = cycleCnt_q;
    progLen_d   = progLen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_LOAD;
          byteReady_d = 1'b1;
          progLen_d   = '0;
          cycleCnt_d  = '0;
          status_d    = ST_OK;
          done_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (transfer) begin
          bramWe_d    = 1'b1;
          bramAddr_d  = progLen_q[ADDR_W-1:0];
          bramWdata_d = i_byte;
          progLen_d   = progLen_q + (ADDR_W+1)'(1);
          if (i_byte_last) begin
            state_d     = S_FLUSH;
            byteReady_d = 1'b0;
          end else if (progLen_q[ADDR_W-1:0] == LAST_ADDR) begin
            // Image does not fit: keep the core in reset and report overflow.
            state_d     = S_DONE;
            byteReady_d = 1'b0;
            status_d    = ST_OVERFLOW;
            done_d      = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        state_d   = S_RUN;
        cpuRstN_d = 1'b1;
      end
      S_RUN: begin
        if (runEnd) begin
          state_d   = S_DONE;
          status_d  = runCode;
          done_d    = 1'b1;
          cpuRstN_d = 1'b0;
        end else if (cycleCnt_q != CNT_MAX) begin
          cycleCnt_d = cycleCnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      byteReady_q <= 1'b0;
      bramWe_q    <= 1'b0;
      bramAddr_q  <= '0;
      bramWdata_q <= '0;
      cpuRstN_q   <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      cycleCnt_q  <= '0;
      progLen_q   <= '0;
    end else begin
      state_q     <= state_d;
      byteReady_q <= byteReady_d;
      bramWe_q    <= bramWe_d;
      bramAddr_q  <= bramAddr_d;
      bramWdata_q <= bramWdata_d;
      cpuRstN_q   <= cpuRstN_d;
      done_q      <= done_d;
      status_q    <= status_d;
      cycleCnt_q  <= cycleCnt_d;
      progLen_q   <= progLen_d;
    end
  end

  assign o_byte_ready = byteReady_q;
  assign o_bram_we    = bramWe_q;
  assign o_bram_addr  = bramAddr_q;
  assign o_bram_wdata = bramWdata_q;
  assign o_cpu_rst_n  = cpuRstN_q;
  assign o_done       = done_q;
  assign o_status     = status_q;
  assign o_cycle_cnt  = cycleCnt_q;
  assign o_prog_len   = progLen_q;

endmodule

// File: tb/tb_wasm_prog_loader.sv
// Bench for wasm_prog_loader: directed vector table, randomized runs against a
// run-outcome model, and a mid-run asynchronous reset sequence.
module tb_wasm_prog_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 500;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start, byteValid, byteLast;
  logic [7:0]        byteData;
  logic              byteReady, bramWe, cpuRstN, done;
  logic [ADDR_W-1:0] bramAddr;
  logic [7:0]        bramWdata;
  logic              instrFinish, instrError, stackExceed, stackEmptyPop;
  logic [2:0]        status;
  logic [31:0]       cycleCnt;
  logic [ADDR_W:0]   progLen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wasm_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start),
    .i_byte_valid(byteValid), .i_byte(byteData), .i_byte_last(byteLast),
    .o_byte_ready(byteReady), .o_bram_we(bramWe), .o_bram_addr(bramAddr),
    .o_bram_wdata(bramWdata), .o_cpu_rst_n(cpuRstN),
    .i_instr_finish(instrFinish), .i_instr_error(instrError),
    .i_stack_exceed(stackExceed), .i_stack_empty_pop(stackEmptyPop),
    .o_done(done), .o_status(status), .o_cycle_cnt(cycleCnt), .o_prog_len(progLen)
  );

  typedef struct {
    string       name;
    int          nBytes;
    bit          toggle;
    bit          noLast;
    bit          useFixed;
    logic [31:0] fixedBytes;
    int          evCycle;
    logic [3:0]  evMask;
    logic [2:0]  expStatus;
    int          expCnt;
    int          expLen;
  } vec_t;

  // Every BRAM write pulse lasts one cycle, so sampling mid-cycle logs each exactly once.
  logic [ADDR_W+7:0] wrLog[$];
  always @(negedge clk) if (rstN && bramWe) wrLog.push_back({bramAddr, bramWdata});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setStatusIn(input logic [3:0] m);
    {instrError, stackExceed, stackEmptyPop, instrFinish} = m;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(byteReady), 0);
    checkOutput({tag, "_we"}, 32'(bramWe), 0);
    checkOutput({tag, "_addr"}, 32'(bramAddr), 0);
    checkOutput({tag, "_wdata"}, 32'(bramWdata), 0);
    checkOutput({tag, "_cpurst"}, 32'(cpuRstN), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_status"}, 32'(status), 0);
    checkOutput({tag, "_cnt"}, cycleCnt, 0);
    checkOutput({tag, "_len"}, 32'(progLen), 0);
  endtask

  // Outcome of a load+run from the rules: overflow if the image never ends within
  // the BRAM, otherwise the first event reported by the core wins unless the
  // timeout budget (TIMEOUT RUN cycles, counter stopping at TIMEOUT-1) runs out first.
  function automatic vec_t modelRun(input vec_t v);
    vec_t r = v;
    r.expLen = v.nBytes;
    if (v.noLast && v.nBytes >= (1 << ADDR_W)) begin
      r.expStatus = 3'd5; r.expCnt = 0; r.expLen = 1 << ADDR_W;
    end else if (v.evCycle >= 0 && v.evCycle < TIMEOUT && v.evMask != 4'b0) begin
      r.expCnt = v.evCycle;
      if (v.evMask[3])      r.expStatus = 3'd1;
      else if (v.evMask[2]) r.expStatus = 3'd2;
      else if (v.evMask[1]) r.expStatus = 3'd3;
      else                  r.expStatus = 3'd0;
    end else begin
      r.expStatus = 3'd4; r.expCnt = TIMEOUT - 1;
    end
    return r;
  endfunction

  function automatic vec_t mkVec(input string name, input int n, input bit tog, input bit noLast,
                                 input int ev, input logic [3:0] mask, input logic [2:0] st,
                                 input int cnt, input int len);
    vec_t v;
    v.name = name; v.nBytes = n; v.toggle = tog; v.noLast = noLast;
    v.useFixed = 1'b0; v.fixedBytes = 32'h0; v.evCycle = ev; v.evMask = mask;
    v.expStatus = st; v.expCnt = cnt; v.expLen = len;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    logic [7:0] bytes [16];
    int sent, guard, runIdx, nChk;
    bit sawRun, phase, ready;
    for (int i = 0; i < 16; i++)
      bytes[i] = (v.useFixed && i < 4) ? v.fixedBytes[31-8*i -: 8] : 8'($urandom);
    wrLog.delete();
    start = 1'b1;
    setStatusIn(4'($urandom));
    tick;
    start = 1'b0;
    sent = 0; guard = 0; phase = 1'b0;
    while (sent < v.nBytes && guard < 100) begin
      ready     = byteReady;
      byteValid = v.toggle ? phase : 1'b1;
      phase     = ~phase;
      byteData  = bytes[sent];
      byteLast  = byteValid ? ((sent == v.nBytes - 1) && !v.noLast) : 1'($urandom);
      setStatusIn(4'($urandom));
      tick;
      if (byteValid && ready) sent++;
      guard++;
    end
    byteValid = 1'b0;
    byteLast  = 1'b0;
    checkOutput({v.name, "_load_in_time"}, 32'(sent), 32'(v.nBytes));
    checkOutput({v.name, "_ready_after_last"}, 32'(byteReady), 0);
    runIdx = 0; sawRun = 1'b0; guard = 0;
    while (!done && guard < 800) begin
      if (cpuRstN) begin
        sawRun = 1'b1;
        setStatusIn((runIdx == v.evCycle) ? v.evMask : 4'b0);
        runIdx++;
      end else begin
        setStatusIn(4'($urandom));
      end
      tick;
      guard++;
    end
    checkOutput({v.name, "_done"}, 32'(done), 1);
    checkOutput({v.name, "_status"}, 32'(status), 32'(v.expStatus));
    checkOutput({v.name, "_cnt"}, cycleCnt, 32'(v.expCnt));
    checkOutput({v.name, "_len"}, 32'(progLen), 32'(v.expLen));
    checkOutput({v.name, "_cpurst"}, 32'(cpuRstN), 0);
    checkOutput({v.name, "_ran"}, 32'(sawRun), (v.expStatus != 3'd5) ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      setStatusIn(4'($urandom));
      tick;
    end
    setStatusIn(4'b0);
    checkOutput({v.name, "_hold_status"}, 32'(status), 32'(v.expStatus));
    checkOutput({v.name, "_hold_cnt"}, cycleCnt, 32'(v.expCnt));
    checkOutput({v.name, "_writes"}, 32'(wrLog.size()), 32'(v.nBytes));
    nChk = (wrLog.size() < v.nBytes) ? wrLog.size() : v.nBytes;
    for (int i = 0; i < nChk; i++)
      checkOutput($sformatf("%s_wr%0d", v.name, i), 32'(wrLog[i]), 32'({ADDR_W'(i), bytes[i]}));
  endtask

  initial begin
    vec_t vecs [8];
    vec_t rv;
    int guard;

    rstN = 1'b1; start = 1'b0; byteValid = 1'b0; byteLast = 1'b0; byteData = 8'h0;
    setStatusIn(4'b0);
    #1 rstN = 1'b0;
    #1 checkResetState("por");
    tick; tick;
    rstN = 1'b1;
    tick;
    checkResetState("idle");

    vecs[0] = mkVec("basic",     4, 0, 0, 10, 4'b0001, 3'd0, 10, 4);
    vecs[0].useFixed = 1'b1; vecs[0].fixedBytes = 32'h41014102;
    vecs[1] = mkVec("toggle",    3, 1, 0, 3,  4'b0001, 3'd0, 3, 3);
    vecs[2] = mkVec("err_fin",   2, 0, 0, 5,  4'b1001, 3'd1, 5, 2);
    vecs[3] = mkVec("exc_pop",   5, 1, 0, 7,  4'b0110, 3'd2, 7, 5);
    vecs[4] = mkVec("pop_first", 1, 0, 0, 0,  4'b0010, 3'd3, 0, 1);
    vecs[5] = mkVec("timeout",   2, 0, 0, -1, 4'b0000, 3'd4, 499, 2);
    vecs[6] = mkVec("overflow", 16, 0, 1, -1, 4'b0000, 3'd5, 0, 16);
    vecs[7] = mkVec("fin_edge",  3, 0, 0, 499, 4'b0001, 3'd0, 499, 3);
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 16; i++) begin
      rv = mkVec($sformatf("rand%0d", i), $urandom_range(1, 15), 1'($urandom), 0,
                 $urandom_range(0, 560), 4'($urandom_range(1, 15)), 3'd0, 0, 0);
      applyStimulus(modelRun(rv));
    end

    // Mid-run reset, with a stray start pulse during RUN that must be ignored.
    start = 1'b1; tick; start = 1'b0;
    byteValid = 1'b1; byteData = 8'hA5; byteLast = 1'b0; tick;
    byteData = 8'h5A; byteLast = 1'b1; tick;
    byteValid = 1'b0; byteLast = 1'b0;
    guard = 0;
    while (!cpuRstN && guard < 10) begin tick; guard++; end
    checkOutput("rst_reached_run", 32'(cpuRstN), 1);
    tick; tick;
    start = 1'b1; tick; start = 1'b0;
    checkOutput("start_ignored_in_run", 32'(cpuRstN), 1);
    tick; tick;
    checkOutput("run_cnt_before_reset", cycleCnt, 5);
    rstN = 1'b0;
    #1 checkResetState("midrun");
    tick;
    rstN = 1'b1;
    tick;
    applyStimulus(mkVec("after_rst", 2, 0, 0, 6, 4'b0001, 3'd0, 6, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
